// File: rtl/cellrv32_dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory (A = CPU data bus, B = DMA).
// One request per cycle goes to DMEM; the loser is parked for one cycle and its response is routed back.
module cellrv32_dmem_arbiter #(
    parameter int PRIO_RR = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    // port A
    input  logic        a_rden_i,
    input  logic        a_wren_i,
    input  logic [3:0]  a_ben_i,
    input  logic [31:0] a_addr_i,
    input  logic [31:0] a_data_i,
    input  logic [3:0]  a_ticket_i,
    output logic [31:0] a_data_o,
    output logic [3:0]  a_ticket_o,
    output logic        a_ack_o,
    output logic        a_err_o,
    // port B
    input  logic        b_rden_i,
    input  logic        b_wren_i,
    input  logic [3:0]  b_ben_i,
    input  logic [31:0] b_addr_i,
    input  logic [31:0] b_data_i,
    input  logic [3:0]  b_ticket_i,
    output logic [31:0] b_data_o,
    output logic [3:0]  b_ticket_o,
    output logic        b_ack_o,
    output logic        b_err_o,
    // DMEM side
    output logic        m_rden_o,
    output logic        m_wren_o,
    output logic [3:0]  m_ben_o,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_data_o,
    output logic [3:0]  m_ticket_o,
    input  logic [31:0] m_data_i,
    input  logic [3:0]  m_ticket_i,
    input  logic        m_ack_i,
    input  logic        m_err_i
);

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    typedef struct packed {
        logic        rden;
        logic        wren;
        logic [3:0]  ben;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  ticket;
    } req_t;

    req_t  pin_a, pin_b;
    req_t  src_a, src_b;
    req_t  gnt_req;
    req_t  pend_a_q, pend_b_q;
    logic  pend_a_vld_q, pend_b_vld_q;

    logic  fresh_a, fresh_b;
    logic  rq_a, rq_b;
    logic  gnt_vld;
    port_t gnt_port;

    port_t last_q;
    port_t owner_q;
    logic  own_vld_q;

    logic  pend_a_issue, pend_b_issue;
    logic  viol_now_a, viol_now_b;
    logic  viol_arm_a_q, viol_arm_b_q;
    logic  viol_rsp_a_q, viol_rsp_b_q;
    logic  viol_err_a_q, viol_err_b_q;

    assign pin_a = {a_rden_i, a_wren_i, a_ben_i, a_addr_i, a_data_i, a_ticket_i};
    assign pin_b = {b_rden_i, b_wren_i, b_ben_i, b_addr_i, b_data_i, b_ticket_i};

    assign fresh_a = a_rden_i | a_wren_i;
    assign fresh_b = b_rden_i | b_wren_i;
    assign rq_a    = fresh_a | pend_a_vld_q;
    assign rq_b    = fresh_b | pend_b_vld_q;

    // A parked request always shadows whatever is on that port's pins.
    assign src_a = pend_a_vld_q ? pend_a_q : pin_a;
    assign src_b = pend_b_vld_q ? pend_b_q : pin_b;

    // A parked loser beats a fresh request, which bounds the wait to one cycle.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_port = PORT_A;
        if (rq_a && rq_b) begin
            gnt_vld = 1'b1;
            if (pend_a_vld_q && !pend_b_vld_q) begin
                gnt_port = PORT_A;
            end else if (pend_b_vld_q && !pend_a_vld_q) begin
                gnt_port = PORT_B;
            end else if (PRIO_RR != 0) begin
                gnt_port = (last_q == PORT_A) ? PORT_B : PORT_A;
            end else begin
                gnt_port = PORT_A;
            end
        end else if (rq_a) begin
            gnt_vld  = 1'b1;
            gnt_port = PORT_A;
        end else if (rq_b) begin
            gnt_vld  = 1'b1;
            gnt_port = PORT_B;
        end
    end

    assign gnt_req = (gnt_port == PORT_A) ? src_a : src_b;

    always_comb begin
        m_rden_o   = 1'b0;
        m_wren_o   = 1'b0;
        m_ben_o    = 4'h0;
        m_addr_o   = 32'h0;
        m_data_o   = 32'h0;
        m_ticket_o = 4'h0;
        if (gnt_vld) begin
            m_rden_o   = gnt_req.rden;
            m_wren_o   = gnt_req.wren;
            m_ben_o    = gnt_req.ben;
            m_addr_o   = gnt_req.addr;
            m_data_o   = gnt_req.data;
            m_ticket_o = gnt_req.ticket;
        end
    end

    assign pend_a_issue = gnt_vld & (gnt_port == PORT_A) & pend_a_vld_q;
    assign pend_b_issue = gnt_vld & (gnt_port == PORT_B) & pend_b_vld_q;
    assign viol_now_a   = fresh_a & pend_a_vld_q;
    assign viol_now_b   = fresh_b & pend_b_vld_q;

    // A violation is remembered until the parked request issues, then surfaces as err
    // two cycles later, i.e. right after the parked request's own response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_a_vld_q <= 1'b0;
            pend_b_vld_q <= 1'b0;
            own_vld_q    <= 1'b0;
            owner_q      <= PORT_A;
            last_q       <= PORT_B;
            viol_arm_a_q <= 1'b0;
            viol_arm_b_q <= 1'b0;
            viol_rsp_a_q <= 1'b0;
            viol_rsp_b_q <= 1'b0;
            viol_err_a_q <= 1'b0;
            viol_err_b_q <= 1'b0;
        end else begin
            if (gnt_vld && (gnt_port == PORT_A)) begin
                pend_a_vld_q <= 1'b0;
            end else if (fresh_a && !pend_a_vld_q) begin
                pend_a_vld_q <= 1'b1;
                pend_a_q     <= pin_a;
            end

            if (gnt_vld && (gnt_port == PORT_B)) begin
                pend_b_vld_q <= 1'b0;
            end else if (fresh_b && !pend_b_vld_q) begin
                pend_b_vld_q <= 1'b1;
                pend_b_q     <= pin_b;
            end

            own_vld_q <= gnt_vld;
            owner_q   <= gnt_port;
            if (gnt_vld) begin
                last_q <= gnt_port;
            end

            viol_arm_a_q <= (viol_arm_a_q | viol_now_a) & ~pend_a_issue;
            viol_arm_b_q <= (viol_arm_b_q | viol_now_b) & ~pend_b_issue;
            viol_rsp_a_q <= pend_a_issue & (viol_arm_a_q | viol_now_a);
            viol_rsp_b_q <= pend_b_issue & (viol_arm_b_q | viol_now_b);
            viol_err_a_q <= viol_rsp_a_q;
            viol_err_b_q <= viol_rsp_b_q;
        end
    end

    always_comb begin
        a_data_o   = 32'h0;
        a_ticket_o = 4'h0;
        a_ack_o    = 1'b0;
        a_err_o    = viol_err_a_q;
        b_data_o   = 32'h0;
        b_ticket_o = 4'h0;
        b_ack_o    = 1'b0;
        b_err_o    = viol_err_b_q;
        if (own_vld_q) begin
            if (owner_q == PORT_A) begin
                a_data_o   = m_data_i;
                a_ticket_o = m_ticket_i;
                a_ack_o    = m_ack_i;
                a_err_o    = m_err_i | viol_err_a_q;
            end else begin
                b_data_o   = m_data_i;
                b_ticket_o = m_ticket_i;
                b_ack_o    = m_ack_i;
                b_err_o    = m_err_i | viol_err_b_q;
            end
        end
    end

endmodule
